// File: rtl/nibble_adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_nib(input int width);
    return width / NIBBLE_W;
  endfunction

  // Counter width is at least one bit so a single-nibble build still has a counter.
  function automatic int cnt_width(input int width);
    int n;
    n = num_nib(width);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fulladder4.sv
// 4-bit ripple-carry adder; the shared datapath slice reused once per nibble.
module fulladder4
  import nibble_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                c_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                c_o
);

  logic [NIBBLE_W:0] total;

  assign total = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, c_i};
  assign sum_o = total[NIBBLE_W-1:0];
  assign c_o   = total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one fulladder4 per clock, LSB nibble first.
// Define ADD_SUB_EN to add the sub_i port and A-B support.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
`ifdef ADD_SUB_EN
  input  logic             sub_i,
`endif
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             busy_o
);

  localparam int NUM_NIB = num_nib(WIDTH);
  localparam int CNT_W   = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NUM_NIB - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CNT_W-1:0] nib_cnt_q;
`ifdef ADD_SUB_EN
  logic             sub_q;
`endif

  logic [WIDTH-1:0]    b_eff;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
  int                  nib_base;

  always_comb begin
`ifdef ADD_SUB_EN
    b_eff = sub_q ? ~b_q : b_q;
`else
    b_eff = b_q;
`endif
    nib_base = int'(nib_cnt_q) * NIBBLE_W;
    nib_a    = a_q[nib_base +: NIBBLE_W];
    nib_b    = b_eff[nib_base +: NIBBLE_W];
  end

  fulladder4 u_fa (
    .a_i   (nib_a),
    .b_i   (nib_b),
    .c_i   (carry_q),
    .sum_o (nib_sum),
    .c_o   (nib_cout)
  );

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      nib_cnt_q <= '0;
`ifdef ADD_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            a_q       <= a_i;
            b_q       <= b_i;
            nib_cnt_q <= '0;
            state_q   <= ADD;
`ifdef ADD_SUB_EN
            sub_q     <= sub_i;
            // Two's-complement subtract: invert B and inject the +1 as carry-in.
            carry_q   <= sub_i ? 1'b1 : carry_i;
`else
            carry_q   <= carry_i;
`endif
          end
        end
        ADD: begin
          sum_q[nib_base +: NIBBLE_W] <= nib_sum;
          carry_q                     <= nib_cout;
          if (nib_cnt_q == LAST_NIB) begin
            state_q <= DONE;
          end else begin
            nib_cnt_q <= nib_cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign busy_o  = (state_q != IDLE);
  assign sum_o   = sum_q;
  assign carry_o = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized checks for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             carry_i;
`ifdef ADD_SUB_EN
  logic             sub_i;
`endif
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             busy_o;

  int          tests_run = 0;
  int          failures  = 0;
  int unsigned cyc       = 0;
  logic [WIDTH:0] exp_res;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .carry_i (carry_i),
`ifdef ADD_SUB_EN
    .sub_i   (sub_i),
`endif
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .carry_o (carry_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready_o && n < 20) begin
      tick();
      n++;
    end
    if (!ready_o) check("ready_timeout", 32'(ready_o), 32'd1);
  endtask

  // Presents one operand set for exactly one accept edge; returns one cycle after accept.
  task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub);
    wait_ready();
    a_i     = a;
    b_i     = b;
    carry_i = cin;
`ifdef ADD_SUB_EN
    sub_i   = sub;
`endif
    exp_res = model(a, b, cin, sub);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  // lat = 1 in the cycle right after the accept edge.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_o && lat < 20) begin
      tick();
      lat++;
    end
    check("valid_timeout", 32'(valid_o), 32'd1);
  endtask

  initial begin
    int lat;
    int unsigned acc_cyc;
    int unsigned prev_cyc;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic rc;
    logic rs;

    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    a_i     = '0;
    b_i     = '0;
    carry_i = 1'b0;
`ifdef ADD_SUB_EN
    sub_i   = 1'b0;
`endif
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_busy",  32'(busy_o),  32'd0);
    check("rst_sum",   32'(sum_o),   32'd0);
    check("rst_carry", 32'(carry_o), 32'd0);

    // 0x1234 + 0x4321
    start(16'h1234, 16'h4321, 1'b0, 1'b0);
    check("t1_busy",  32'(busy_o),  32'd1);
    check("t1_ready", 32'(ready_o), 32'd0);
    wait_valid(lat);
    check("t1_latency", 32'(lat), 32'd5);
    check("t1_sum",   32'(sum_o),   32'h5555);
    check("t1_carry", 32'(carry_o), 32'd0);
    tick();
    check("t1_ready_after", 32'(ready_o), 32'd1);
    check("t1_valid_after", 32'(valid_o), 32'd0);

    // Carry ripples through every nibble cycle
    start(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_valid(lat);
    check("t2_latency", 32'(lat), 32'd5);
    check("t2_sum",   32'(sum_o),   32'h0000);
    check("t2_carry", 32'(carry_o), 32'd1);
    tick();

    // Back-pressure and a stray valid_i pulse while busy
    ready_i = 1'b0;
    start(16'h00FF, 16'h0000, 1'b1, 1'b0);
    a_i     = 16'hAAAA;
    b_i     = 16'h5555;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    wait_valid(lat);
    check("t3_sum",   32'(sum_o),   32'h0100);
    check("t3_carry", 32'(carry_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_hold_valid", 32'(valid_o), 32'd1);
      check("t3_hold_sum",   32'(sum_o),   32'h0100);
      check("t3_hold_carry", 32'(carry_o), 32'd0);
      check("t3_hold_ready", 32'(ready_o), 32'd0);
    end
    ready_i = 1'b1;
    tick();
    check("t3_release_valid", 32'(valid_o), 32'd0);
    check("t3_release_ready", 32'(ready_o), 32'd1);
    tick();
    check("t3_no_stray_txn", 32'(busy_o), 32'd0);

    // Reset during the second ADD cycle
    start(16'h1111, 16'h2222, 1'b0, 1'b0);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t4_rst_ready", 32'(ready_o), 32'd1);
    check("t4_rst_valid", 32'(valid_o), 32'd0);
    check("t4_rst_busy",  32'(busy_o),  32'd0);
    check("t4_rst_sum",   32'(sum_o),   32'd0);
    check("t4_rst_carry", 32'(carry_o), 32'd0);
    start(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_valid(lat);
    check("t4_sum",   32'(sum_o),   32'h0002);
    check("t4_carry", 32'(carry_o), 32'd0);
    tick();

`ifdef ADD_SUB_EN
    start(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_valid(lat);
    check("sub_neg_sum",   32'(sum_o),   32'hFFFE);
    check("sub_neg_carry", 32'(carry_o), 32'd0);
    tick();
    start(16'h0007, 16'h0005, 1'b0, 1'b1);
    wait_valid(lat);
    check("sub_pos_sum",   32'(sum_o),   32'h0002);
    check("sub_pos_carry", 32'(carry_o), 32'd1);
    tick();
`endif

    // Back-to-back with valid_i and ready_i held high
    ready_i  = 1'b1;
    valid_i  = 1'b1;
    prev_cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      wait_ready();
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
`ifdef ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      a_i     = ra;
      b_i     = rb;
      carry_i = rc;
`ifdef ADD_SUB_EN
      sub_i   = rs;
`endif
      exp_res = model(ra, rb, rc, rs);
      tick();
      acc_cyc = cyc;
      if (i > 0) check("b2b_interval", acc_cyc - prev_cyc, 32'd6);
      prev_cyc = acc_cyc;
      wait_valid(lat);
      check("b2b_latency", 32'(lat), 32'd5);
      check("b2b_sum",   32'(sum_o),   32'(exp_res[WIDTH-1:0]));
      check("b2b_carry", 32'(carry_o), 32'(exp_res[WIDTH]));
    end
    valid_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
